// File: rtl/fixed_mul_pkg.sv
// Shared constants and state type for the sequential fixed-point multiplier.
package fixed_mul_pkg;

   // Operand/result width, unsigned fixed point with two integer bits.
   localparam int unsigned DefaultWidth = 28;

   // Number of fraction bits for a given operand width.
   function automatic int unsigned frac_bits(input int unsigned width);
      return width - 2;
   endfunction

   localparam int unsigned FRAC = frac_bits(DefaultWidth);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

endpackage

// File: rtl/fixed_mul_dp.sv
// Shift-add datapath: operand shift registers, 2*WIDTH accumulator and bit counter.
module fixed_mul_dp
   import fixed_mul_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth,
   localparam int unsigned CntW = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load_i,
   input  logic             step_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             last_o,
   output logic [WIDTH-1:0] res_o,
   output logic             ovf_o
);

   localparam int unsigned Frac = frac_bits(WIDTH);

   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [CntW-1:0]    cnt_q, cnt_d;

   // Load clears the accumulator; each step consumes one multiplier bit, LSB first.
   always_comb begin
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      if (load_i) begin
         mcand_d  = {{WIDTH{1'b0}}, a_i};
         mplier_d = b_i;
         acc_d    = '0;
         cnt_d    = '0;
      end else if (step_i) begin
         if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
         end
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + 1'b1;
      end
   end

   // Datapath state registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
      end else begin
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
      end
   end

   // The step taking the counter past WIDTH-1 completes the product.
   assign last_o = (cnt_q == CntW'(WIDTH - 1));

   // Taken from the next-state accumulator so the top can register it on the final step.
   assign res_o = acc_d[2*WIDTH-3:Frac];
   assign ovf_o = |acc_d[2*WIDTH-1:2*WIDTH-2];

endmodule

// File: rtl/fixed_mul_seq.sv
// Sequential unsigned fixed-point multiplier with valid/ready handshakes on both sides.
module fixed_mul_seq
   import fixed_mul_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] multiplicand,
   input  logic [WIDTH-1:0] multiplier,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] product,
   output logic             overflow
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] product_q, product_d;
   logic             overflow_q, overflow_d;
   logic             load, step, last;
   logic [WIDTH-1:0] res;
   logic             ovf;

   fixed_mul_dp #(
      .WIDTH (WIDTH)
   ) u_dp (
      .clk     (clk),
      .reset_n (reset_n),
      .load_i  (load),
      .step_i  (step),
      .a_i     (multiplicand),
      .b_i     (multiplier),
      .last_o  (last),
      .res_o   (res),
      .ovf_o   (ovf)
   );

   // Next-state and datapath control; result is latched on the final RUN step.
   always_comb begin
      state_d    = state_q;
      product_d  = product_q;
      overflow_d = overflow_q;
      load       = 1'b0;
      step       = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               load    = 1'b1;
               state_d = StRun;
            end
         end
         StRun: begin
            step = 1'b1;
            if (last) begin
               state_d    = StDone;
               product_d  = res;
               overflow_d = ovf;
            end
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and registered result.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         product_q  <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         product_q  <= product_d;
         overflow_q <= overflow_d;
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign product   = product_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_fixed_mul_seq.sv
// Self-checking bench for fixed_mul_seq: directed table, hold/reset sequences, random ops.
module tb_fixed_mul_seq;

   localparam int unsigned W = 28;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic [W-1:0] multiplicand = '0;
   logic [W-1:0] multiplier = '0;
   logic         in_ready, out_valid, overflow;
   logic [W-1:0] product;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   fixed_mul_seq #(
      .WIDTH (W)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .product      (product),
      .overflow     (overflow)
   );

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] p;
      logic         ov;
      string        name;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: full product by plain arithmetic, then pick the fixed-point window.
   function automatic void ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] p, output logic ov);
      longint unsigned aa, bb, full;
      aa   = 64'(a);
      bb   = 64'(b);
      full = aa * bb;
      p    = W'(full >> (W - 2));
      ov   = (full >> (2 * W - 2)) != 0;
   endfunction

   // Issue one operation and wait for out_valid; lat counts edges after the accept edge.
   // Called and returns at #1 after a rising edge.
   task automatic start_and_wait(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input bit noise, output int lat);
      int n;
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("in_ready before issue", 64'(in_ready), 64'd1);
      in_valid     = 1'b1;
      multiplicand = a;
      multiplier   = b;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat      = 0;
      while (!out_valid && lat < 100) begin
         if (noise) begin
            multiplicand = W'($urandom);
            multiplier   = W'($urandom);
            in_valid     = 1'($urandom % 2);
            out_ready    = 1'($urandom % 2);
         end
         @(posedge clk);
         #1;
         lat++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
   endtask

   task automatic pop();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("pop in_ready", 64'(in_ready), 64'd1);
      chk("pop out_valid", 64'(out_valid), 64'd0);
   endtask

   initial begin
      int           lat;
      logic [W-1:0] ep;
      logic         eov;

      vecs[0] = '{a: 28'h4000000, b: 28'h4000000, p: 28'h4000000, ov: 1'b0, name: "1.0*1.0"};
      vecs[1] = '{a: 28'h3000000, b: 28'h2000000, p: 28'h1800000, ov: 1'b0, name: "0.75*0.5"};
      vecs[2] = '{a: 28'hE000000, b: 28'hE000000, p: 28'h1000000, ov: 1'b1, name: "3.5*3.5"};
      vecs[3] = '{a: 28'h0000001, b: 28'h0000001, p: 28'h0000000, ov: 1'b0, name: "lsb*lsb"};
      vecs[4] = '{a: 28'hFFFFFFF, b: 28'hFFFFFFF, p: 28'h0000000, ov: 1'b1, name: "max*max"};
      ref_mul(vecs[4].a, vecs[4].b, ep, eov);
      vecs[4].p  = ep;
      vecs[4].ov = eov;

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      chk("reset in_ready", 64'(in_ready), 64'd1);
      chk("reset out_valid", 64'(out_valid), 64'd0);
      chk("reset product", 64'(product), 64'd0);
      chk("reset overflow", 64'(overflow), 64'd0);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed table.
      for (int i = 0; i < 5; i++) begin
         start_and_wait(vecs[i].a, vecs[i].b, i != 0, lat);
         chk({vecs[i].name, " latency"}, 64'(lat), 64'(W));
         chk({vecs[i].name, " product"}, 64'(product), 64'(vecs[i].p));
         chk({vecs[i].name, " overflow"}, 64'(overflow), 64'(vecs[i].ov));
         pop();
      end

      // Hold in DONE while in_valid and operands toggle.
      ref_mul(28'h3000000, 28'h6000000, ep, eov);
      start_and_wait(28'h3000000, 28'h6000000, 1'b0, lat);
      for (int i = 0; i < 5; i++) begin
         in_valid     = ~in_valid;
         multiplicand = W'($urandom);
         multiplier   = W'($urandom);
         @(posedge clk);
         #1;
         chk("hold product", 64'(product), 64'(ep));
         chk("hold overflow", 64'(overflow), 64'(eov));
         chk("hold out_valid", 64'(out_valid), 64'd1);
         chk("hold in_ready", 64'(in_ready), 64'd0);
      end
      in_valid = 1'b0;
      pop();

      // Reset in the middle of RUN, then accept on the first edge after release.
      in_valid     = 1'b1;
      multiplicand = 28'hFFFFFFF;
      multiplier   = 28'hFFFFFFF;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      chk("mid reset in_ready", 64'(in_ready), 64'd1);
      chk("mid reset out_valid", 64'(out_valid), 64'd0);
      chk("mid reset product", 64'(product), 64'd0);
      chk("mid reset overflow", 64'(overflow), 64'd0);
      in_valid     = 1'b1;
      multiplicand = 28'h2000000;
      multiplier   = 28'h6000000;
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("accept after reset", 64'(in_ready), 64'd0);
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("post-reset latency", 64'(lat), 64'(W));
      chk("post-reset product", 64'(product), 64'h3000000);
      chk("post-reset overflow", 64'(overflow), 64'd0);
      pop();

      // Random operands with noise during RUN and random stalls in DONE.
      for (int i = 0; i < 20; i++) begin
         logic [W-1:0] a, b;
         int stall;
         a = W'($urandom);
         b = W'($urandom);
         ref_mul(a, b, ep, eov);
         start_and_wait(a, b, 1'b1, lat);
         chk("rand latency", 64'(lat), 64'(W));
         chk("rand product", 64'(product), 64'(ep));
         chk("rand overflow", 64'(overflow), 64'(eov));
         stall = $urandom_range(0, 4);
         for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            #1;
            chk("rand stall out_valid", 64'(out_valid), 64'd1);
            chk("rand stall product", 64'(product), 64'(ep));
         end
         pop();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fixed_mul_seq.md
FIXED_MUL_SEQ -- requirements
Module: fixed_mul_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 28, giving the operand/result width in unsigned fixed point, radix point between bits WIDTH-3 and WIDTH-2 (two integer bits).
REQ-002 The block SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-003 The block SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port in_valid  input  1  operand pair present.
REQ-005 The block SHALL have port in_ready  output  1  block can accept operands.
REQ-006 The block SHALL have port multiplicand  input  WIDTH  operand A.
REQ-007 The block SHALL have port multiplier  input  WIDTH  operand B.
REQ-008 The block SHALL have port out_valid  output  1  product present.
REQ-009 The block SHALL have port out_ready  input  1  consumer takes product.
REQ-010 The block SHALL have port product  output  WIDTH  truncated fixed-point A*B.
REQ-011 The block SHALL have port overflow  output  1  product integer part exceeds two bits.

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-013 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-014 On an edge with in_valid=1 in IDLE, the block SHALL capture both operands, clear the 2*WIDTH-bit accumulator and the bit counter, and enter RUN.
REQ-015 Each RUN edge SHALL process one multiplier bit, LSB first: if set, add the shifted multiplicand to the accumulator; then shift and increment the counter.
REQ-016 After exactly WIDTH RUN edges, the FSM SHALL enter DONE, so out_valid rises WIDTH edges after the accept edge.
REQ-017 With full = A*B (2*WIDTH bits), product SHALL equal full[2*WIDTH-3 : WIDTH-2] (truncation, no rounding).
REQ-018 overflow SHALL equal the OR of full[2*WIDTH-1 : 2*WIDTH-2].
REQ-019 In DONE, product and overflow SHALL hold stable until an edge with out_ready=1; that edge SHALL return the FSM to IDLE.
REQ-020 in_valid SHALL be ignored outside IDLE; operand changes after acceptance SHALL NOT affect the result.
REQ-021 out_ready outside DONE SHALL have no effect.
REQ-022 An input handshake and output handshake SHALL NOT occur in the same cycle (no overlap); throughput is one result per WIDTH+2 cycles minimum.
REQ-023 product and overflow SHALL be registered outputs; no combinational path from inputs to outputs.

Reset
REQ-024 reset_n=0 SHALL immediately force IDLE, counter 0, accumulator 0, product 0, overflow 0, out_valid 0, in_ready 1.
REQ-025 Reset asserted in RUN or DONE SHALL abandon the operation; no stale result SHALL appear after release.
REQ-026 The first edge after reset_n rises SHALL be able to accept an operand pair.

Structure
REQ-027 A shared package SHALL hold the default WIDTH, the fraction-bit constant FRAC = WIDTH-2, and the state enum type (IDLE, RUN, DONE).
REQ-028 The shift-add datapath (operand shift registers, accumulator, counter) SHALL be a sub-module, fixed_mul_dp. The FSM and handshake logic SHALL stay in fixed_mul_seq.
REQ-029 Counter width SHALL be $clog2(WIDTH+1) bits.

Verification (WIDTH=28)
REQ-030 0x4000000 * 0x4000000 (1.0*1.0) -> product 0x4000000, overflow 0, out_valid exactly 28 edges after accept.
REQ-031 0x3000000 * 0x2000000 (0.75*0.5) -> product 0x1800000, overflow 0.
REQ-032 0xE000000 * 0xE000000 (3.5*3.5) -> product 0x1000000, overflow 1; 0x0000001 * 0x0000001 -> product 0, overflow 0.
REQ-033 Hold out_ready=0 for 5 cycles in DONE while toggling in_valid and operands -> product stable, in_ready 0, no new operation accepted; out_ready=1 -> IDLE next edge.
REQ-034 Pulse reset_n low at RUN edge 10, release, then issue 0x2000000 * 0x6000000 (0.5*1.5) -> no out_valid before the new operation completes; product 0x3000000, overflow 0.
REQ-035 Back-to-back: 20 random operand pairs with random out_ready stalls, compared against the truncated reference product and overflow -> all match, no lost or duplicated results.
